// File: rtl/load_store_unit.sv
// Load/store unit: steers byte lanes onto a word-wide data-memory port and splits misaligned accesses
// into two beats. Outputs are registered or decoded from state; one memory beat is outstanding at a time.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter bit SPLIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            modeBU,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;
  state_t state, state_nxt;

  logic                  ready_q, we_q, split_q, beat_q, err_q;
  logic [2:0]            mode_q;
  logic [1:0]            off_q;
  logic [3:0]            mask_q;
  logic [DATA_WIDTH-1:0] wdata_q, b0_q, rdata_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic       mode_ok;
  logic [2:0] size;
  logic [3:0] mask;
  logic [1:0] off;
  logic       split_need, bad, accept, pend, advance;
  logic [2:0] rem;
  logic [4:0] sh0;
  logic [5:0] sh1;
  logic [DATA_WIDTH-1:0] raw, ext;

  always_comb begin
    mode_ok = 1'b1;
    size    = 3'd4;
    mask    = 4'b1111;
    case (modeBU)
      3'b001:          begin size = 3'd4; mask = 4'b1111; end
      3'b010, 3'b100:  begin size = 3'd2; mask = 4'b0011; end
      3'b011, 3'b101:  begin size = 3'd1; mask = 4'b0001; end
      default:         mode_ok = 1'b0;
    endcase
  end

  assign off        = addr[1:0];
  assign split_need = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign bad        = !mode_ok || (split_need && !SPLIT_EN);
  assign accept     = (state == IDLE) && ready_q && req_valid;
  assign pend       = split_q && !beat_q;
  // Stores move to beat1 on grant; loads only once beat0 data has returned.
  assign advance    = ((state == ISSUE) && mem_gnt && we_q && pend) ||
                      ((state == WAIT_R) && mem_rvalid && pend);

  assign rem = 3'd4 - {1'b0, off_q};
  assign sh0 = {off_q, 3'b000};
  assign sh1 = {rem, 3'b000};

  always_comb begin
    raw = split_q ? ((b0_q >> sh0) | (mem_rdata << sh1)) : (mem_rdata >> sh0);
    case (mode_q)
      3'b010:  ext = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      3'b011:  ext = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      3'b100:  ext = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
      3'b101:  ext = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad ? RESP : ISSUE;
      ISSUE:   if (mem_gnt) begin
                 if (we_q) state_nxt = pend ? ISSUE : RESP;
                 else      state_nxt = WAIT_R;
               end
      WAIT_R:  if (mem_rvalid) state_nxt = pend ? ISSUE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      beat_q      <= 1'b0;
      err_q       <= 1'b0;
      mode_q      <= 3'd0;
      off_q       <= 2'd0;
      mask_q      <= 4'd0;
      wdata_q     <= '0;
      b0_q        <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= '0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        we_q        <= req_write;
        split_q     <= split_need;
        beat_q      <= 1'b0;
        err_q       <= bad;
        mode_q      <= modeBU;
        off_q       <= off;
        mask_q      <= mask;
        wdata_q     <= wdata;
        rdata_q     <= '0;
        mem_we_q    <= req_write;
        mem_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        mem_be_q    <= mask << off;
        mem_wdata_q <= wdata << {off, 3'b000};
      end
      if (advance) begin
        beat_q      <= 1'b1;
        mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
        mem_be_q    <= mask_q >> rem;
        mem_wdata_q <= wdata_q >> sh1;
      end
      if ((state == WAIT_R) && mem_rvalid) begin
        if (pend) b0_q    <= mem_rdata;
        else      rdata_q <= ext;
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state == RESP);
  assign mem_req    = (state == ISSUE);
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a bench-side memory responder drives grants/read data and
// compares every beat and response against hand-computed values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  modeBU;
  logic [31:0] addr, wdata, rdata;
  logic        resp_valid, err;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        ns_req_valid, ns_req_ready, ns_resp_valid, ns_err, ns_mem_req, ns_mem_we;
  logic [31:0] ns_rdata, ns_mem_addr, ns_mem_wdata;
  logic [3:0]  ns_mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .modeBU(modeBU), .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_EN(1'b0)) u_nosplit (
    .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_write(req_write),
    .modeBU(modeBU), .addr(addr), .wdata(wdata), .resp_valid(ns_resp_valid), .rdata(ns_rdata),
    .err(ns_err), .mem_req(ns_mem_req), .mem_gnt(mem_gnt), .mem_we(ns_mem_we), .mem_addr(ns_mem_addr),
    .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request with an ideal memory: grant in the same cycle as mem_req, read data the cycle after.
  task automatic run_txn(input string tag, input logic wr, input logic [2:0] mode,
                         input logic [31:0] a, input logic [31:0] wd, input int nbeats,
                         input logic [31:0] ea0, input logic [3:0] eb0, input logic [31:0] ew0,
                         input logic [31:0] ea1, input logic [3:0] eb1, input logic [31:0] ew1,
                         input logic [31:0] rd0, input logic [31:0] rd1,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int   beats = 0;
    int   lat   = 0;
    logic got   = 1'b0;
    logic rv_pend = 1'b0;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; modeBU = mode; addr = a; wdata = wd;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      lat++;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (beats == 1) ? rd0 : rd1;
        rv_pend    = 1'b0;
      end
      if (resp_valid) begin
        got = 1'b1;
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".err"},   32'(err), 32'(exp_err));
        chk({tag, ".lat"},   32'(lat), 32'(exp_lat));
        chk({tag, ".beats"}, 32'(beats), 32'(nbeats));
      end else if (mem_req) begin
        if (beats < nbeats) begin
          chk({tag, ".we"},    32'(mem_we), 32'(wr));
          chk({tag, ".addr"},  mem_addr, (beats == 0) ? ea0 : ea1);
          chk({tag, ".be"},    32'(mem_be), 32'((beats == 0) ? eb0 : eb1));
          chk({tag, ".wdata"}, mem_wdata, (beats == 0) ? ew0 : ew1);
        end else begin
          chk({tag, ".extra_beat"}, 32'(beats + 1), 32'(nbeats));
        end
        mem_gnt = 1'b1;
        rv_pend = !wr;
        beats++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!got) chk({tag, ".timeout"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic ns_got, ns_seen;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; modeBU = 3'b000; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; ns_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.resp",  32'(resp_valid), 32'd0);
    chk("rst.memreq", 32'(mem_req), 32'd0);
    chk("rst.addr",  mem_addr, 32'h0);
    chk("rst.be",    32'(mem_be), 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready_after", 32'(req_ready), 32'd1);

    //      tag     wr   mode    addr          wdata         n  a0            be0      wd0           a1            be1      wd1           rd0           rd1           rdata         err lat
    run_txn("sw",   1, 3'b001, 32'h00000100, 32'hDEADBEEF, 1, 32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        32'h00000000, 0, 2);
    run_txn("sb",   1, 3'b011, 32'h00000103, 32'h000000A5, 1, 32'h00000100, 4'b1000, 32'hA5000000, 32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        32'h00000000, 0, 2);
    run_txn("shw",  1, 3'b010, 32'hFFFFFFFF, 32'h00001234, 2, 32'hFFFFFFFC, 4'b1000, 32'h34000000, 32'h00000000, 4'b0001, 32'h00000012, 32'h0,        32'h0,        32'h00000000, 0, 3);
    run_txn("lb",   0, 3'b011, 32'h00000102, 32'h0,        1, 32'h00000100, 4'b0100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00800000, 32'h0,        32'hFFFFFF80, 0, 3);
    run_txn("lbu",  0, 3'b101, 32'h00000102, 32'h0,        1, 32'h00000100, 4'b0100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00800000, 32'h0,        32'h00000080, 0, 3);
    run_txn("lh",   0, 3'b010, 32'h00000101, 32'h0,        1, 32'h00000100, 4'b0110, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hAB8001CD, 32'h0,        32'hFFFF8001, 0, 3);
    run_txn("lwx",  0, 3'b001, 32'h000001FE, 32'h0,        2, 32'h000001FC, 4'b1100, 32'h0,        32'h00000200, 4'b0011, 32'h0,        32'h1111AAAA, 32'hBBBB2222, 32'h22221111, 0, 5);
    run_txn("lhux", 0, 3'b100, 32'h00000103, 32'h0,        2, 32'h00000100, 4'b1000, 32'h0,        32'h00000104, 4'b0001, 32'h0,        32'h7F000000, 32'h000000C3, 32'h0000C37F, 0, 5);
    run_txn("bad0", 1, 3'b000, 32'h00000100, 32'h12345678, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        32'h00000000, 1, 1);
    run_txn("bad6", 0, 3'b110, 32'h00000100, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        32'h00000000, 1, 1);

    // Grant withheld: request must hold steady, then reset abandons the load in WAIT_R.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; modeBU = 3'b001; addr = 32'h00000040;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall.req",  32'(mem_req), 32'd1);
      chk("stall.addr", mem_addr, 32'h00000040);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("waitr.memreq", 32'(mem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.memreq", 32'(mem_req), 32'd0);
    chk("mrst.resp",   32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("mrst.ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mrst.late_rvalid", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    run_txn("lw_after", 0, 3'b001, 32'h00000200, 32'h0, 1, 32'h00000200, 4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0,
            32'h12345678, 32'h0, 32'h12345678, 0, 3);

    // Split disabled: misaligned word load errors out without touching memory.
    @(negedge clk);
    chk("ns.ready", 32'(ns_req_ready), 32'd1);
    req_write = 1'b0; modeBU = 3'b001; addr = 32'h00000001; ns_req_valid = 1'b1;
    ns_got = 1'b0; ns_seen = 1'b0;
    for (int c = 0; c < 10 && !ns_got; c++) begin
      @(negedge clk);
      ns_req_valid = 1'b0;
      if (ns_mem_req) ns_seen = 1'b1;
      if (ns_resp_valid) begin
        ns_got = 1'b1;
        chk("ns.err",   32'(ns_err), 32'd1);
        chk("ns.rdata", ns_rdata, 32'h0);
      end
    end
    chk("ns.resp",   32'(ns_got), 32'd1);
    chk("ns.memreq", 32'(ns_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
